// File: rtl/sirv_gnrl_skid_buf.sv
// sirv_gnrl_skid_buf: two-entry valid/ready skid buffer with registered
// o_vld/o_dat and i_rdy, breaking both the forward and backward timing paths.
module sirv_gnrl_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    o_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;
  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic          vld_q, rdy_q;
  logic          in_fire, out_fire;
  assign in_fire  = i_vld & rdy_q;
  assign out_fire = vld_q & o_rdy;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        main_d  = i_dat;
        state_d = BUSY;
      end
      BUSY: if (in_fire && out_fire) main_d = i_dat;
      else if (in_fire) begin
        skid_d  = i_dat;
        state_d = FULL;
      end else if (out_fire) state_d = EMPTY;
      FULL: if (out_fire) begin
        main_d  = skid_q;
        state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    // data regs may still load under flush; o_vld=0 hides them
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      vld_q   <= state_d != EMPTY;
      rdy_q   <= state_d != FULL;
    end
  end
  assign i_rdy = rdy_q;
  assign o_vld = vld_q;
  assign o_dat = main_q;
  assign o_cnt = state_q;
endmodule

// File: tb/tb_sirv_gnrl_skid_buf.sv
// tb_sirv_gnrl_skid_buf: vector table, directed sequences and random traffic
// checked against a queue-based model of the two-entry buffer.
module tb_sirv_gnrl_skid_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        i_vld = 1'b0;
  logic        i_rdy;
  logic [31:0] i_dat = '0;
  logic        o_vld;
  logic        o_rdy = 1'b0;
  logic [31:0] o_dat;
  logic [1:0]  o_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];

  sirv_gnrl_skid_buf #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f, v;
    logic [31:0] d;
    logic        r, e_vld, e_rdy;
    logic [1:0]  e_cnt;
    logic [31:0] e_dat;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: entries are a FIFO of depth 2; fires use the model's view of i_rdy/o_vld
  task automatic cyc(input logic f, input logic v, input logic [31:0] d, input logic r);
    logic in_f, out_f;
    flush = f; i_vld = v; i_dat = d; o_rdy = r;
    in_f  = v && q.size() < 2;
    out_f = r && q.size() > 0;
    @(posedge clk);
    if (out_f) void'(q.pop_front());
    if (in_f) q.push_back(d);
    if (f) q.delete();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".vld"}, 32'(o_vld), 32'(q.size() != 0));
    chk({tag, ".rdy"}, 32'(i_rdy), 32'(q.size() < 2));
    chk({tag, ".cnt"}, 32'(o_cnt), 32'(q.size()));
    if (q.size() != 0) chk({tag, ".dat"}, o_dat, q[0]);
  endtask

  initial begin
    logic [31:0] pend;
    logic        v;
    tbl[0]  = '{1'b0, 1'b1, 32'h1,  1'b0, 1'b1, 1'b1, 2'd1, 32'h1};
    tbl[1]  = '{1'b0, 1'b1, 32'h2,  1'b0, 1'b1, 1'b0, 2'd2, 32'h1};
    tbl[2]  = '{1'b0, 1'b1, 32'h3,  1'b0, 1'b1, 1'b0, 2'd2, 32'h1};
    tbl[3]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 2'd1, 32'h2};
    tbl[4]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 2'd1, 32'h3};
    tbl[5]  = '{1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 2'd1, 32'h4};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
    tbl[8]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11};
    tbl[9]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 2'd1, 32'h55};
    tbl[12] = '{1'b1, 1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0};

    i_vld = 1'b1; i_dat = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", 32'(o_vld), 32'h0);
    chk("rst.rdy", 32'(i_rdy), 32'h1);
    chk("rst.cnt", 32'(o_cnt), 32'h0);
    chk("rst.dat", o_dat, 32'h0);
    rst_n = 1'b1;
    q.delete();
    cyc(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    chk("post_rst.vld", 32'(o_vld), 32'h1);
    chk("post_rst.dat", o_dat, 32'hA5A5A5A5);

    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, 32'(k), 1'b1);
      chk("stream.dat", o_dat, 32'(k));
      chk("stream.cnt", 32'(o_cnt), 32'h1);
      chk("stream.rdy", 32'(i_rdy), 32'h1);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain.vld", 32'(o_vld), 32'h0);

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d.vld", i), 32'(o_vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.rdy", i), 32'(i_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.cnt", i), 32'(o_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d.dat", i), o_dat, tbl[i].e_dat);
    end

    pend = $urandom;
    v = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      logic was_rdy;
      was_rdy = q.size() < 2;
      if (!(v && !was_rdy)) v = ($urandom_range(3) != 0);
      cyc(($urandom_range(63) == 0), v, pend, ($urandom_range(2) != 0));
      if (v && was_rdy) begin
        pend = $urandom;
        v = 1'b0;
      end
      chk_model("rnd");
    end

    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'hAA, 1'b0);
    cyc(1'b0, 1'b1, 32'hBB, 1'b0);
    chk("full.cnt", 32'(o_cnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.vld", 32'(o_vld), 32'h0);
    chk("arst.cnt", 32'(o_cnt), 32'h0);
    chk("arst.dat", o_dat, 32'h0);
    chk("arst.rdy", 32'(i_rdy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
